// File: rtl/sa_merge_pkg.sv
// Shared types and helpers for the leaf round-robin merge stage.
package sa_merge_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam int PKT_CNT_W = 16;

  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_rr_pick.sv
// Rotate-priority picker: first requester after ptr, wrapping modulo NUM_SRC.
module sa_rr_pick
  import sa_merge_pkg::*;
#(
  parameter int NUM_SRC = 5,
  parameter int SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sa_leaf_rr_merge.sv
// Packet-aware round-robin merge of leaf streams into one registered
// output, with grant lock across multi-beat packets and a packet counter.
module sa_leaf_rr_merge
  import sa_merge_pkg::*;
#(
  parameter int NUM_SRC = 5,
  parameter int DATA_W  = 16,
  parameter int SRC_W   = src_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_last,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [SRC_W-1:0]          out_src,
  output logic [PKT_CNT_W-1:0]      pkt_count
);

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [SRC_W-1:0]    lock_q, lock_d;
  logic [SRC_W-1:0]    pick_idx, sel;
  logic [NUM_SRC-1:0]  pick_gnt, grant;
  logic                locked, load, xfer, sel_last;
  logic [DATA_W-1:0]   sel_data;

  sa_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req     (src_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  assign locked    = (state_q == LOCKED);
  assign grant     = locked ? (NUM_SRC'(1) << lock_q) : pick_gnt;
  assign sel       = locked ? lock_q : pick_idx;
  // Ready is held low while reset is applied, not just after it.
  assign load      = !rst && (!out_valid || out_ready);
  assign src_ready = grant & {NUM_SRC{load}};
  assign xfer      = |(src_valid & src_ready);
  assign sel_data  = src_data[int'(sel)*DATA_W +: DATA_W];
  assign sel_last  = src_last[sel];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          if (sel_last) begin
            ptr_d = sel;
          end else begin
            state_d = LOCKED;
            lock_d  = sel;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d = IDLE;
            ptr_d   = lock_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= SRC_W'(NUM_SRC - 1);
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (out_valid && out_ready && out_last
                 && pkt_count != '1) begin
      pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sa_leaf_rr_merge.sv
// Scoreboard bench for sa_leaf_rr_merge: model pushes beats, output pops.
module tb_sa_leaf_rr_merge;

  localparam int N = 5;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_last;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [2:0]     out_src;
  logic [15:0]    pkt_count;

  sa_leaf_rr_merge #(.NUM_SRC(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_data  (src_data),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    log_src[$];
  int    log_data[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle while inputs are stable.
  bit          m_locked;
  int          m_ptr;
  int          m_lock;
  bit          m_ov;
  logic [15:0] m_cnt;

  always @(negedge clk) begin
    bit         found;
    bit         ld;
    int         g;
    logic [4:0] exp_rdy;
    beat_t      b;
    if (rst) begin
      m_locked = 0;
      m_ptr    = N - 1;
      m_lock   = 0;
      m_ov     = 0;
      m_cnt    = 0;
      sb.delete();
    end else begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
      ld    = !m_ov || out_ready;
      found = 0;
      g     = 0;
      if (m_locked) begin
        found = 1;
        g     = m_lock;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!found && src_valid[j]) begin
            found = 1;
            g     = j;
          end
        end
      end
      exp_rdy = (found && ld) ? 5'(1 << g) : 5'd0;
      chk("src_ready", 32'(src_ready), 32'(exp_rdy));
      if (m_ov) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          b = sb[0];
          chk("out_src", 32'(out_src), 32'(b.src));
          chk("out_data", 32'(out_data), 32'(b.data));
          chk("out_last", 32'(out_last), 32'(b.last));
          if (out_ready) begin
            void'(sb.pop_front());
            log_src.push_back(b.src);
            log_data.push_back(int'(b.data));
            if (b.last && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
          end
        end
      end
      if (found && ld && src_valid[g]) begin
        b.src  = g;
        b.data = src_data[g*W +: W];
        b.last = src_last[g];
        sb.push_back(b);
        if (!m_locked && !b.last) begin
          m_locked = 1;
          m_lock   = g;
        end else if (!m_locked) begin
          m_ptr = g;
        end else if (b.last) begin
          m_locked = 0;
          m_ptr    = m_lock;
        end
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic l,
                         input logic [15:0] d);
    src_valid[i]       = v;
    src_last[i]        = l;
    src_data[i*W +: W] = d;
  endtask

  task automatic clr_log();
    log_src.delete();
    log_data.delete();
  endtask

  initial begin
    int guard;
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 4, 0};
    rst       = 1'b0;
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    cyc(2);
    rst       = 1'b0;
    out_ready = 1'b1;

    // Single-beat arbitration across all sources
    clr_log();
    for (int i = 0; i < N; i++) set_src(i, 1, 1, 16'(16'h0010 * i + 1));
    cyc(6);
    src_valid = '0;
    cyc(2);
    chk("t1_beats", 32'(log_src.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_src.size(); i++)
      chk("t1_order", 32'(log_src[i]), 32'(exp_seq[i]));
    chk("t1_pkt_count", 32'(pkt_count), 32'd6);

    // Packet lock on source 2 while source 3 waits
    clr_log();
    set_src(3, 1, 1, 16'h00B3);
    set_src(2, 1, 0, 16'h00A0);
    cyc();
    chk("t2_rdy3_a", 32'(src_ready[3]), 32'd0);
    set_src(2, 1, 0, 16'h00A1);
    cyc();
    chk("t2_rdy3_b", 32'(src_ready[3]), 32'd0);
    set_src(2, 1, 1, 16'h00A2);
    chk("t2_rdy3_c", 32'(src_ready[3]), 32'd0);
    cyc();
    set_src(2, 0, 0, 16'h0);
    cyc();
    set_src(3, 0, 0, 16'h0);
    cyc(2);
    chk("t2_beats", 32'(log_src.size()), 32'd4);
    if (log_src.size() == 4) begin
      chk("t2_src0", 32'(log_src[0]), 32'd2);
      chk("t2_src2", 32'(log_src[2]), 32'd2);
      chk("t2_src3", 32'(log_src[3]), 32'd3);
      chk("t2_d0", 32'(log_data[0]), 32'h00A0);
      chk("t2_d1", 32'(log_data[1]), 32'h00A1);
      chk("t2_d2", 32'(log_data[2]), 32'h00A2);
    end

    // Backpressure hold
    clr_log();
    set_src(0, 1, 1, 16'h1234);
    cyc();
    out_ready = 1'b0;
    set_src(0, 1, 1, 16'h5678);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_hold_data", 32'(out_data), 32'h1234);
      chk("t3_hold_rdy", 32'(src_ready), 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    set_src(0, 0, 0, 16'h0);
    cyc(2);
    chk("t3_beats", 32'(log_data.size()), 32'd2);
    if (log_data.size() == 2) begin
      chk("t3_d0", 32'(log_data[0]), 32'h1234);
      chk("t3_d1", 32'(log_data[1]), 32'h5678);
    end

    // Locked source stalls mid-packet
    clr_log();
    set_src(1, 1, 0, 16'h00B0);
    set_src(4, 1, 1, 16'h00D4);
    cyc();
    set_src(1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_rdy4", 32'(src_ready[4]), 32'd0);
      cyc();
    end
    set_src(1, 1, 1, 16'h00B1);
    cyc();
    set_src(1, 0, 0, 16'h0);
    cyc();
    set_src(4, 0, 0, 16'h0);
    cyc(2);
    chk("t4_beats", 32'(log_src.size()), 32'd3);
    if (log_src.size() == 3) begin
      chk("t4_src1", 32'(log_src[1]), 32'd1);
      chk("t4_src4", 32'(log_src[2]), 32'd4);
    end

    // Reset while locked on source 3
    set_src(3, 1, 0, 16'h00C0);
    cyc();
    set_src(3, 1, 0, 16'h00C1);
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_pkt_count", 32'(pkt_count), 32'd0);
    chk("t5_src_ready", 32'(src_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_src(0, 1, 1, 16'h00E0);
    set_src(3, 1, 1, 16'h00C2);
    cyc();
    chk("t5_first_src", 32'(out_src), 32'd0);
    set_src(0, 0, 0, 16'h0);
    cyc();
    set_src(3, 0, 0, 16'h0);
    cyc(2);

    // Counter saturation
    for (int i = 0; i < N; i++) set_src(i, 1, 1, 16'(i));
    guard = 0;
    while (m_cnt < 16'hFFFE && guard < 70000) begin
      cyc();
      guard++;
    end
    chk("t6_reach_fffe", 32'(guard < 70000), 32'd1);
    cyc(3);
    src_valid = '0;
    cyc(3);
    chk("t6_sat", 32'(pkt_count), 32'hFFFF);
    set_src(2, 1, 1, 16'h0002);
    cyc(2);
    src_valid = '0;
    cyc(3);
    chk("t6_sat_hold", 32'(pkt_count), 32'hFFFF);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
